// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: arbitrates NPORTS requesters onto an 8-bit RAM/IO bus.
// Each word, half-word or byte access is split into consecutive byte cycles.
// Load data is returned sign- or zero-extended on a shared response bus.
// IO stores stall while the IO write buffer is full.
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration.
// Without it, arbitration is fixed priority and the lowest eligible port wins.
module mem_port_arbiter #(
    parameter int          NPORTS  = 2,
    parameter logic [31:0] IO_BASE = 32'h0003_0000
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic [7:0]            mem_read,
    output logic [7:0]            mem_write,
    output logic [31:0]           mem_addr,
    output logic                  r_nw_out,
    input  logic                  io_buffer_full,
    input  logic [NPORTS-1:0]     req_valid,
    input  logic [32*NPORTS-1:0]  req_addr,
    input  logic [32*NPORTS-1:0]  req_wdata,
    input  logic [NPORTS-1:0]     req_r_nw,
    input  logic [3*NPORTS-1:0]   req_type,
    output logic [NPORTS-1:0]     req_ready,
    output logic [NPORTS-1:0]     resp_valid,
    output logic [31:0]           resp_data,
    output logic                  busy
);
    localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    typedef enum logic [1:0] {IDLE, XFER, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              r_nw_q, r_nw_d;
    logic [2:0]        type_q, type_d;
    logic [PW-1:0]     port_q, port_d;
    logic [2:0]        n_q, n_d;
    logic [2:0]        k_q, k_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [NPORTS-1:0] resp_valid_q, resp_valid_d;
    logic [31:0]       resp_data_q, resp_data_d;

    logic [NPORTS-1:0] eligible;
    logic              grant_found;
    logic [PW-1:0]     grant_idx;
    logic              accept;
    logic              stall;
    logic [1:0]        k_prev;
    logic [31:0]       load_word;
    logic [NPORTS-1:0] port_onehot;

    // Number of byte cycles needed for an access type; unknown types move one byte.
    function automatic logic [2:0] byte_count(input logic [2:0] t);
        case (t)
            3'b000:         byte_count = 3'd4;
            3'b001, 3'b101: byte_count = 3'd2;
            default:        byte_count = 3'd1;
        endcase
    endfunction

    // Sign or zero extension of the assembled load word; unknown types give 0.
    function automatic logic [31:0] extend(input logic [2:0] t, input logic [31:0] w);
        case (t)
            3'b000:  extend = w;
            3'b001:  extend = {16'h0000, w[15:0]};
            3'b101:  extend = {{16{w[15]}}, w[15:0]};
            3'b010:  extend = {24'h000000, w[7:0]};
            3'b110:  extend = {{24{w[7]}}, w[7:0]};
            default: extend = 32'h0000_0000;
        endcase
    endfunction

    // A request is eligible unless it is an IO store facing a full IO buffer.
    always_comb begin
        for (int i = 0; i < NPORTS; i++) begin
            eligible[i] = req_valid[i] &&
                          !(!req_r_nw[i] && (req_addr[32*i +: 32] >= IO_BASE) && io_buffer_full);
        end
    end

`ifdef MEM_ARB_RR_EN
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    logic [PW-1:0] rr_cand;

    // Round-robin search starting one past the last granted port.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        rr_cand     = '0;
        for (int off = 1; off <= NPORTS; off++) begin
            rr_cand = PW'((int'(rr_ptr_q) + off) % NPORTS);
            if (!grant_found && eligible[rr_cand]) begin
                grant_found = 1'b1;
                grant_idx   = rr_cand;
            end
        end
    end

    // Pointer remembers the most recent accepted port.
    always_comb begin
        rr_ptr_d = accept ? grant_idx : rr_ptr_q;
    end

    // Pointer register; reset so the first search starts at port 0.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rr_ptr_q <= PW'(NPORTS - 1);
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    // Fixed priority: the lowest eligible index wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = NPORTS - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                grant_found = 1'b1;
                grant_idx   = PW'(i);
            end
        end
    end
`endif

    // Accept strobe and one-hot decode of the granted and latched ports.
    always_comb begin
        accept = (state_q == IDLE) && rdy_in && grant_found;
        for (int i = 0; i < NPORTS; i++) begin
            req_ready[i]   = accept && (grant_idx == PW'(i));
            port_onehot[i] = (port_q == PW'(i));
        end
    end

    // IO stores hold the current byte while the IO buffer is full.
    always_comb begin
        stall = (state_q == XFER) && !r_nw_q && (addr_q >= IO_BASE) && io_buffer_full;
    end

    // Bus drive: only a non-stalled XFER cycle puts a byte on the bus.
    always_comb begin
        mem_addr  = 32'h0000_0000;
        mem_write = 8'h00;
        r_nw_out  = 1'b1;
        if ((state_q == XFER) && !stall) begin
            mem_addr = addr_q + {29'd0, k_q};
            r_nw_out = r_nw_q;
            if (!r_nw_q) begin
                mem_write = wdata_q[{k_q[1:0], 3'b000} +: 8];
            end
        end
    end

    // Next-state logic: latch on accept, step bytes, capture load data, respond.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        r_nw_d       = r_nw_q;
        type_d       = type_q;
        port_d       = port_q;
        n_d          = n_q;
        k_d          = k_q;
        rdata_d      = rdata_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        k_prev       = k_q[1:0] - 2'd1;
        load_word    = rdata_q;
        load_word[{k_prev, 3'b000} +: 8] = mem_read;
        if (rdy_in) begin
            case (state_q)
                IDLE: begin
                    resp_valid_d = '0;
                    if (grant_found) begin
                        state_d = XFER;
                        k_d     = 3'd0;
                        rdata_d = 32'h0000_0000;
                        port_d  = grant_idx;
                        for (int i = 0; i < NPORTS; i++) begin
                            if (grant_idx == PW'(i)) begin
                                addr_d  = req_addr[32*i +: 32];
                                wdata_d = req_wdata[32*i +: 32];
                                r_nw_d  = req_r_nw[i];
                                type_d  = req_type[3*i +: 3];
                                n_d     = byte_count(req_type[3*i +: 3]);
                            end
                        end
                    end
                end
                XFER: begin
                    if (!stall) begin
                        k_d = k_q + 3'd1;
                        if (r_nw_q && (k_q != 3'd0)) begin
                            rdata_d = load_word;
                        end
                        if (k_q == n_q - 3'd1) begin
                            if (r_nw_q) begin
                                state_d = WAIT;
                            end else begin
                                state_d      = RESP;
                                resp_valid_d = port_onehot;
                                resp_data_d  = 32'h0000_0000;
                            end
                        end
                    end
                end
                WAIT: begin
                    state_d      = RESP;
                    rdata_d      = load_word;
                    resp_valid_d = port_onehot;
                    resp_data_d  = extend(type_q, load_word);
                end
                RESP: begin
                    state_d      = IDLE;
                    resp_valid_d = '0;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers; reset drops any access in flight.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            r_nw_q       <= 1'b1;
            type_q       <= '0;
            port_q       <= '0;
            n_q          <= '0;
            k_q          <= '0;
            rdata_q      <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            r_nw_q       <= r_nw_d;
            type_q       <= type_d;
            port_q       <= port_d;
            n_q          <= n_d;
            k_q          <= k_d;
            rdata_q      <= rdata_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter with two ports.
// Expected grant order follows MEM_ARB_RR_EN when the macro is defined.
module tb_mem_port_arbiter;

   localparam int NP = 2;

   logic            clk;
   logic            rst;
   logic            rdy;
   logic [7:0]      memRead;
   logic [7:0]      memWrite;
   logic [31:0]     memAddr;
   logic            rNwOut;
   logic            ioFull;
   logic [NP-1:0]   reqValid;
   logic [32*NP-1:0] reqAddr;
   logic [32*NP-1:0] reqWdata;
   logic [NP-1:0]   reqRnw;
   logic [3*NP-1:0] reqType;
   logic [NP-1:0]   reqReady;
   logic [NP-1:0]   respValid;
   logic [31:0]     respData;
   logic            busyOut;

   logic [7:0]      ram [0:1023];
   int              checks;
   int              errors;

   mem_port_arbiter #(.NPORTS(NP), .IO_BASE(32'h0003_0000)) dut (
      .clk_in         (clk),
      .rst_in         (rst),
      .rdy_in         (rdy),
      .mem_read       (memRead),
      .mem_write      (memWrite),
      .mem_addr       (memAddr),
      .r_nw_out       (rNwOut),
      .io_buffer_full (ioFull),
      .req_valid      (reqValid),
      .req_addr       (reqAddr),
      .req_wdata      (reqWdata),
      .req_r_nw       (reqRnw),
      .req_type       (reqType),
      .req_ready      (reqReady),
      .resp_valid     (respValid),
      .resp_data      (respData),
      .busy           (busyOut)
   );

   // Free-running clock, 10 ns period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory model: returns the byte at the previous cycle's address.
   always @(posedge clk) begin
      memRead <= ram[memAddr[9:0]];
   end

   // Hard time limit so the run can never hang.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Count one comparison and report it if it does not match.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
      end
   endtask

   // Advance to 1 ns after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive the request fields of one port.
   task automatic applyStimulus(input int port, input logic [31:0] addr, input logic [31:0] wd,
                                input logic rnw, input logic [2:0] typ);
      reqAddr[port*32 +: 32]  = addr;
      reqWdata[port*32 +: 32] = wd;
      reqRnw[port]            = rnw;
      reqType[port*3 +: 3]    = typ;
   endtask

   // Full access on one port: returns cycles from accept to resp_valid and the data.
   task automatic runAccess(input int port, input logic [31:0] addr, input logic [31:0] wd,
                            input logic rnw, input logic [2:0] typ,
                            output int lat, output logic [31:0] data);
      int waitCnt;
      applyStimulus(port, addr, wd, rnw, typ);
      reqValid[port] = 1'b1;
      waitCnt = 0;
      lat = -1;
      data = 32'h0;
      #2;
      while (!reqReady[port] && waitCnt < 20) begin
         tick();
         #2;
         waitCnt++;
      end
      if (!reqReady[port]) begin
         checkOutput("acceptTimeout", 32'd0, 32'd1);
         reqValid[port] = 1'b0;
         return;
      end
      tick();
      reqValid[port] = 1'b0;
      lat = 1;
      #2;
      while (!respValid[port] && lat < 40) begin
         tick();
         #2;
         lat++;
      end
      if (!respValid[port]) begin
         checkOutput("respTimeout", 32'd0, 32'd1);
      end
      data = respData;
   endtask

   // Main directed sequence.
   initial begin
      int lat;
      int pulses;
      int cnt;
      logic [31:0] data;
      logic [NP-1:0] grants [$];
      logic [NP-1:0] expGrants [4];

      checks   = 0;
      errors   = 0;
      rst      = 1'b1;
      rdy      = 1'b1;
      ioFull   = 1'b0;
      reqValid = '0;
      reqAddr  = '0;
      reqWdata = '0;
      reqRnw   = '0;
      reqType  = '0;
      for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
      ram[10'h100] = 8'h11;
      ram[10'h101] = 8'h22;
      ram[10'h102] = 8'h33;
      ram[10'h103] = 8'h44;
      ram[10'h200] = 8'h34;
      ram[10'h201] = 8'h9A;
      ram[10'h210] = 8'h80;

      // Reset state.
      tick();
      tick();
      checkOutput("rstBusy", {31'd0, busyOut}, 32'd0);
      checkOutput("rstRespValid", {30'd0, respValid}, 32'd0);
      checkOutput("rstRespData", respData, 32'd0);
      checkOutput("rstMemAddr", memAddr, 32'd0);
      checkOutput("rstRnw", {31'd0, rNwOut}, 32'd1);
      rst = 1'b0;
      tick();

      // Word load on port 0 with per-cycle address checks.
      applyStimulus(0, 32'h100, 32'h0, 1'b1, 3'b000);
      reqValid[0] = 1'b1;
      #2;
      checkOutput("lwReady", {30'd0, reqReady}, 32'b01);
      tick();
      reqValid[0] = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #2;
         checkOutput("lwAddr", memAddr, 32'h100 + k);
         checkOutput("lwRnw", {31'd0, rNwOut}, 32'd1);
         tick();
      end
      #2;
      checkOutput("lwWaitIdleBus", memAddr, 32'd0);
      checkOutput("lwNoEarlyResp", {30'd0, respValid}, 32'd0);
      tick();
      #2;
      checkOutput("lwRespValid", {30'd0, respValid}, 32'b01);
      checkOutput("lwRespData", respData, 32'h4433_2211);
      tick();
      #2;
      checkOutput("lwBusyDone", {31'd0, busyOut}, 32'd0);
      tick();

      // Half-word and byte loads with extension and latency.
      runAccess(0, 32'h200, 32'h0, 1'b1, 3'b101, lat, data);
      checkOutput("lhData", data, 32'hFFFF_9A34);
      checkOutput("lhLat", lat, 32'd4);
      tick();
      runAccess(1, 32'h200, 32'h0, 1'b1, 3'b001, lat, data);
      checkOutput("lhuData", data, 32'h0000_9A34);
      tick();
      runAccess(0, 32'h210, 32'h0, 1'b1, 3'b110, lat, data);
      checkOutput("lbData", data, 32'hFFFF_FF80);
      checkOutput("lbLat", lat, 32'd3);
      tick();
      runAccess(1, 32'h210, 32'h0, 1'b1, 3'b010, lat, data);
      checkOutput("lbuData", data, 32'h0000_0080);
      tick();

      // rdy_in low in IDLE blocks acceptance.
      rdy = 1'b0;
      applyStimulus(0, 32'h100, 32'h0, 1'b1, 3'b000);
      reqValid[0] = 1'b1;
      #2;
      checkOutput("rdyLowReady", {30'd0, reqReady}, 32'd0);
      tick();
      reqValid[0] = 1'b0;
      #2;
      checkOutput("rdyLowBusy", {31'd0, busyOut}, 32'd0);
      rdy = 1'b1;
      tick();

      // IO store blocked by full buffer while a load on port 1 proceeds.
      ioFull = 1'b1;
      applyStimulus(0, 32'h0003_0000, 32'hA1B2_C3D4, 1'b0, 3'b000);
      reqValid[0] = 1'b1;
      applyStimulus(1, 32'h210, 32'h0, 1'b1, 3'b110);
      reqValid[1] = 1'b1;
      #2;
      checkOutput("ioBlockedGrant", {30'd0, reqReady}, 32'b10);
      tick();
      reqValid[1] = 1'b0;
      cnt = 0;
      #2;
      while (!respValid[1] && cnt < 20) begin
         tick();
         #2;
         cnt++;
      end
      checkOutput("concLoadResp", {30'd0, respValid}, 32'b10);
      checkOutput("concLoadData", respData, 32'hFFFF_FF80);
      tick();
      ioFull = 1'b0;
      #2;
      checkOutput("ioStoreReady", {30'd0, reqReady}, 32'b01);
      tick();
      reqValid[0] = 1'b0;
      #2;
      checkOutput("swAddr0", memAddr, 32'h0003_0000);
      checkOutput("swByte0", {24'd0, memWrite}, 32'hD4);
      checkOutput("swRnw0", {31'd0, rNwOut}, 32'd0);
      tick();
      #2;
      checkOutput("swAddr1", memAddr, 32'h0003_0001);
      checkOutput("swByte1", {24'd0, memWrite}, 32'hC3);
      tick();
      ioFull = 1'b1;
      for (int s = 0; s < 3; s++) begin
         #2;
         checkOutput("swStallAddr", memAddr, 32'd0);
         checkOutput("swStallRnw", {31'd0, rNwOut}, 32'd1);
         tick();
      end
      ioFull = 1'b0;
      #2;
      checkOutput("swAddr2", memAddr, 32'h0003_0002);
      checkOutput("swByte2", {24'd0, memWrite}, 32'hB2);
      tick();
      #2;
      checkOutput("swAddr3", memAddr, 32'h0003_0003);
      checkOutput("swByte3", {24'd0, memWrite}, 32'hA1);
      tick();
      #2;
      checkOutput("swRespValid", {30'd0, respValid}, 32'b01);
      checkOutput("swRespData", respData, 32'd0);
      tick();
      tick();

      // rdy_in low for two cycles mid-store: address holds, response slips by two.
      applyStimulus(0, 32'h40, 32'h5566_7788, 1'b0, 3'b000);
      reqValid[0] = 1'b1;
      #2;
      checkOutput("frzReady", {30'd0, reqReady}, 32'b01);
      tick();
      reqValid[0] = 1'b0;
      #2;
      checkOutput("frzAddr0", memAddr, 32'h40);
      checkOutput("frzByte0", {24'd0, memWrite}, 32'h88);
      tick();
      rdy = 1'b0;
      #2;
      checkOutput("frzAddrA", memAddr, 32'h41);
      tick();
      #2;
      checkOutput("frzAddrB", memAddr, 32'h41);
      tick();
      rdy = 1'b1;
      #2;
      checkOutput("frzAddrC", memAddr, 32'h41);
      checkOutput("frzByte1", {24'd0, memWrite}, 32'h77);
      tick();
      #2;
      checkOutput("frzAddr2", memAddr, 32'h42);
      tick();
      #2;
      checkOutput("frzAddr3", memAddr, 32'h43);
      checkOutput("frzNoEarlyResp", {30'd0, respValid}, 32'd0);
      tick();
      #2;
      checkOutput("frzRespValid", {30'd0, respValid}, 32'b01);
      tick();
      tick();

      // Asynchronous reset in the middle of a word load.
      applyStimulus(0, 32'h100, 32'h0, 1'b1, 3'b000);
      reqValid[0] = 1'b1;
      #2;
      checkOutput("midRstReady", {30'd0, reqReady}, 32'b01);
      tick();
      reqValid[0] = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      checkOutput("midRstAddr", memAddr, 32'd0);
      checkOutput("midRstRnw", {31'd0, rNwOut}, 32'd1);
      checkOutput("midRstBusy", {31'd0, busyOut}, 32'd0);
      #3;
      rst = 1'b0;
      pulses = 0;
      for (int c = 0; c < 10; c++) begin
         tick();
         #2;
         if (respValid != '0) pulses++;
      end
      checkOutput("midRstNoResp", pulses, 32'd0);
      tick();
      runAccess(0, 32'h100, 32'h0, 1'b1, 3'b000, lat, data);
      checkOutput("postRstData", data, 32'h4433_2211);
      checkOutput("postRstLat", lat, 32'd6);
      tick();

      // Arbitration with both ports requesting continuously, from a fresh reset.
      rst = 1'b1;
      #2;
      rst = 1'b0;
      tick();
      applyStimulus(0, 32'h210, 32'h0, 1'b1, 3'b110);
      applyStimulus(1, 32'h210, 32'h0, 1'b1, 3'b110);
      reqValid = 2'b11;
      for (int c = 0; c < 100 && grants.size() < 4; c++) begin
         #2;
         if (reqReady != '0) grants.push_back(reqReady);
         if (grants.size() < 4) tick();
      end
      tick();
      reqValid = '0;
`ifdef MEM_ARB_RR_EN
      expGrants = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
      expGrants = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
      checkOutput("arbCount", grants.size(), 32'd4);
      for (int g = 0; g < 4; g++) begin
         if (g < grants.size()) begin
            checkOutput("arbGrant", {30'd0, grants[g]}, {30'd0, expGrants[g]});
         end
      end
      cnt = 0;
      #2;
      while (busyOut && cnt < 20) begin
         tick();
         #2;
         cnt++;
      end
      checkOutput("arbDrain", {31'd0, busyOut}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
